// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pkg
//  Purpose  : Shared state encoding and fetch constants for fetch_unit.
//  Revision : 1.0
// ============================================================================
package fetch_pkg;

    localparam int unsigned PC_STEP   = 4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_HOLD   = 2'd2,
        ST_COMMIT = 2'd3
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction-fetch FSM between the pc register and decode, with
//             memory handshake, decode stall buffering and branch redirect.
//  Revision : 1.0
// ============================================================================
module fetch_unit #(
    parameter int               WIDTH     = 32,
    parameter int unsigned      PC_STEP   = fetch_pkg::PC_STEP,
    parameter logic [WIDTH-1:0] NOP_INSTR = WIDTH'(fetch_pkg::NOP_INSTR)
) (
    input  logic             Clock_in,
    input  logic             Signal_reset,
    input  logic [WIDTH-1:0] Pc_in,
    output logic [WIDTH-1:0] Pc_next,
    output logic             Pc_write,
    output logic             Mem_req,
    output logic [WIDTH-1:0] Mem_addr,
    input  logic             Mem_ready,
    input  logic [WIDTH-1:0] Mem_data,
    input  logic             Stall_in,
    input  logic             Branch_taken,
    input  logic [WIDTH-1:0] Branch_target,
    output logic [WIDTH-1:0] Instr_out,
    output logic [WIDTH-1:0] Pc_out,
    output logic             Valid_out
);
    import fetch_pkg::*;

    fetch_state_e     state_q, state_d;
    logic             mem_req_q, mem_req_d;
    logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0] pc_next_q, pc_next_d;
    logic             pc_write_q, pc_write_d;
    logic [WIDTH-1:0] instr_out_q, instr_out_d;
    logic [WIDTH-1:0] pc_out_q, pc_out_d;
    logic             valid_out_q, valid_out_d;
    logic             redir_flag_q, redir_flag_d;
    logic [WIDTH-1:0] redir_target_q, redir_target_d;
    logic [WIDTH-1:0] hold_instr_q, hold_instr_d;
    logic [WIDTH-1:0] hold_pc_q, hold_pc_d;

    always_comb begin
        state_d        = state_q;
        mem_req_d      = mem_req_q;
        mem_addr_d     = mem_addr_q;
        pc_next_d      = pc_next_q;
        pc_write_d     = 1'b0;
        instr_out_d    = instr_out_q;
        pc_out_d       = pc_out_q;
        valid_out_d    = 1'b0;
        redir_flag_d   = redir_flag_q;
        redir_target_d = redir_target_q;
        hold_instr_d   = hold_instr_q;
        hold_pc_d      = hold_pc_q;

        case (state_q)
            ST_LOAD: begin
                if (Branch_taken) begin
                    pc_next_d  = Branch_target;
                    pc_write_d = 1'b1;
                    state_d    = ST_COMMIT;
                end else begin
                    mem_addr_d = Pc_in;
                    mem_req_d  = 1'b1;
                    state_d    = ST_WAIT;
                end
            end

            ST_WAIT: begin
                // The memory read cannot be aborted; remember the redirect instead.
                if (Branch_taken) begin
                    redir_flag_d   = 1'b1;
                    redir_target_d = Branch_target;
                end
                if (Mem_ready) begin
                    mem_req_d = 1'b0;
                    if (Branch_taken || redir_flag_q) begin
                        pc_next_d    = Branch_taken ? Branch_target : redir_target_q;
                        pc_write_d   = 1'b1;
                        redir_flag_d = 1'b0;
                        state_d      = ST_COMMIT;
                    end else if (!Stall_in) begin
                        instr_out_d = Mem_data;
                        pc_out_d    = mem_addr_q;
                        valid_out_d = 1'b1;
                        pc_next_d   = mem_addr_q + WIDTH'(PC_STEP);
                        pc_write_d  = 1'b1;
                        state_d     = ST_COMMIT;
                    end else begin
                        hold_instr_d = Mem_data;
                        hold_pc_d    = mem_addr_q;
                        state_d      = ST_HOLD;
                    end
                end
            end

            ST_HOLD: begin
                if (Branch_taken) begin
                    pc_next_d  = Branch_target;
                    pc_write_d = 1'b1;
                    state_d    = ST_COMMIT;
                end else if (!Stall_in) begin
                    instr_out_d = hold_instr_q;
                    pc_out_d    = hold_pc_q;
                    valid_out_d = 1'b1;
                    pc_next_d   = hold_pc_q + WIDTH'(PC_STEP);
                    pc_write_d  = 1'b1;
                    state_d     = ST_COMMIT;
                end
            end

            ST_COMMIT: begin
                // A branch here replaces the PC update that is about to land.
                if (Branch_taken) begin
                    pc_next_d  = Branch_target;
                    pc_write_d = 1'b1;
                end else begin
                    state_d = ST_LOAD;
                end
            end

            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge Clock_in) begin
        if (Signal_reset) begin
            state_q        <= ST_LOAD;
            mem_req_q      <= 1'b0;
            mem_addr_q     <= '0;
            pc_next_q      <= '0;
            pc_write_q     <= 1'b0;
            instr_out_q    <= NOP_INSTR;
            pc_out_q       <= '0;
            valid_out_q    <= 1'b0;
            redir_flag_q   <= 1'b0;
            redir_target_q <= '0;
            hold_instr_q   <= '0;
            hold_pc_q      <= '0;
        end else begin
            state_q        <= state_d;
            mem_req_q      <= mem_req_d;
            mem_addr_q     <= mem_addr_d;
            pc_next_q      <= pc_next_d;
            pc_write_q     <= pc_write_d;
            instr_out_q    <= instr_out_d;
            pc_out_q       <= pc_out_d;
            valid_out_q    <= valid_out_d;
            redir_flag_q   <= redir_flag_d;
            redir_target_q <= redir_target_d;
            hold_instr_q   <= hold_instr_d;
            hold_pc_q      <= hold_pc_d;
        end
    end

    assign Pc_next   = pc_next_q;
    assign Pc_write  = pc_write_q;
    assign Mem_req   = mem_req_q;
    assign Mem_addr  = mem_addr_q;
    assign Instr_out = instr_out_q;
    assign Pc_out    = pc_out_q;
    assign Valid_out = valid_out_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Self-checking bench for fetch_unit with a pc-register model,
//             latency-controlled instruction memory and an expected-fetch queue.
//  Revision : 1.0
// ============================================================================
module tb_fetch_unit;

    logic        clk;
    logic        Signal_reset;
    logic [31:0] Pc_in;
    logic [31:0] Pc_next;
    logic        Pc_write;
    logic        Mem_req;
    logic [31:0] Mem_addr;
    logic        Mem_ready;
    logic [31:0] Mem_data;
    logic        Stall_in;
    logic        Branch_taken;
    logic [31:0] Branch_target;
    logic [31:0] Instr_out;
    logic [31:0] Pc_out;
    logic        Valid_out;

    fetch_unit dut (
        .Clock_in      (clk),
        .Signal_reset  (Signal_reset),
        .Pc_in         (Pc_in),
        .Pc_next       (Pc_next),
        .Pc_write      (Pc_write),
        .Mem_req       (Mem_req),
        .Mem_addr      (Mem_addr),
        .Mem_ready     (Mem_ready),
        .Mem_data      (Mem_data),
        .Stall_in      (Stall_in),
        .Branch_taken  (Branch_taken),
        .Branch_target (Branch_target),
        .Instr_out     (Instr_out),
        .Pc_out        (Pc_out),
        .Valid_out     (Valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc_next;
    } exp_t;

    typedef struct {
        bit          do_reset;
        int          lat;
        logic [31:0] pc;
        logic [31:0] instr;
        int          vcyc;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[6];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          latency = 0;
    int          wait_cnt = 0;
    int          req_cnt = 0;
    int          last_req = 0;
    int          addr_jumps = 0;
    int          b2b = 0;
    logic [31:0] pc_model = '0;
    logic        prev_req = 1'b0;
    logic [31:0] prev_addr = '0;
    logic        prev_valid = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0000) return 32'h8C01_0004;
        if (a == 32'h0000_0004) return 32'h0022_1820;
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock: update pc/memory models from pre-edge values, then sample.
    task automatic tick();
        logic        pw, req, rdy, rst;
        logic [31:0] pn;
        exp_t        e;
        pw  = (Pc_write === 1'b1);
        pn  = Pc_next;
        req = (Mem_req === 1'b1);
        rdy = Mem_ready;
        rst = Signal_reset;
        @(posedge clk);
        cyc++;
        if (rst) begin
            pc_model = '0;
            wait_cnt = 0;
        end else begin
            if (pw) pc_model = pn;
            wait_cnt = (req && !rdy) ? wait_cnt + 1 : 0;
        end
        #1;
        Pc_in     = pc_model;
        Mem_ready = (Mem_req === 1'b1) && (wait_cnt >= latency);
        Mem_data  = mem_word(Mem_addr);
        if (Mem_req === 1'b1) begin
            if (prev_req && Mem_addr !== prev_addr) addr_jumps++;
            req_cnt++;
        end
        prev_req  = (Mem_req === 1'b1);
        prev_addr = Mem_addr;
        if (Valid_out === 1'b1) begin
            if (prev_valid) b2b++;
            check("valid_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("pc_out", Pc_out, e.pc);
                check("instr_out", Instr_out, e.instr);
                check("pc_next", Pc_next, e.pc_next);
                check("pc_write_at_valid", 32'(Pc_write), 32'd1);
            end
            last_req = req_cnt;
            req_cnt  = 0;
        end
        prev_valid = (Valid_out === 1'b1);
    endtask

    task automatic do_reset();
        Signal_reset = 1'b1;
        tick();
        Signal_reset = 1'b0;
        cyc     = 1;
        req_cnt = 0;
    endtask

    task automatic run_until_valid(input string nm, input int exp_cyc);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (Valid_out === 1'b1) begin
                check(nm, cyc, exp_cyc);
                return;
            end
        end
        check({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic push(input logic [31:0] pc);
        exp_t e;
        e.pc      = pc;
        e.instr   = mem_word(pc);
        e.pc_next = pc + 32'd4;
        sb.push_back(e);
    endtask

    initial begin
        Signal_reset  = 1'b1;
        Pc_in         = '0;
        Mem_ready     = 1'b0;
        Mem_data      = '0;
        Stall_in      = 1'b0;
        Branch_taken  = 1'b0;
        Branch_target = '0;

        vecs[0] = '{1'b1, 0, 32'h0, 32'h8C01_0004, 3};
        vecs[1] = '{1'b0, 0, 32'h4, 32'h0022_1820, 6};
        vecs[2] = '{1'b0, 2, 32'h8, 32'h5A5A_0008, 11};
        vecs[3] = '{1'b0, 1, 32'hC, 32'h5A5A_000C, 15};
        vecs[4] = '{1'b1, 3, 32'h0, 32'h8C01_0004, 6};
        vecs[5] = '{1'b0, 0, 32'h4, 32'h0022_1820, 9};

        // Reset state
        tick();
        tick();
        check("rst_mem_req", 32'(Mem_req), 32'd0);
        check("rst_mem_addr", Mem_addr, 32'd0);
        check("rst_pc_write", 32'(Pc_write), 32'd0);
        check("rst_pc_next", Pc_next, 32'd0);
        check("rst_instr_out", Instr_out, 32'h0000_0000);
        check("rst_pc_out", Pc_out, 32'd0);
        check("rst_valid_out", 32'(Valid_out), 32'd0);

        // Sequential fetches with varying memory latency
        foreach (vecs[k]) begin
            if (vecs[k].do_reset) do_reset();
            latency = vecs[k].lat;
            push(vecs[k].pc);
            run_until_valid($sformatf("vec%0d_valid_cycle", k), vecs[k].vcyc);
            check($sformatf("vec%0d_req_cycles", k), last_req, vecs[k].lat + 1);
        end

        // Decode stall while the word arrives: two cycles in HOLD
        do_reset();
        latency = 0;
        push(32'h0);
        run_until_valid("stall_first_valid", 3);
        push(32'h4);
        tick();
        Stall_in = 1'b1;
        tick();
        tick();
        check("stall_c6_instr_kept", Instr_out, 32'h8C01_0004);
        check("stall_c6_pc_write", 32'(Pc_write), 32'd0);
        check("stall_c6_valid", 32'(Valid_out), 32'd0);
        tick();
        check("stall_c7_instr_kept", Instr_out, 32'h8C01_0004);
        check("stall_c7_pc_write", 32'(Pc_write), 32'd0);
        Stall_in = 1'b0;
        run_until_valid("stall_release_valid", 8);

        // Branch during WAIT, data arrives a cycle later and is discarded
        latency = 1;
        tick();
        tick();
        Branch_taken  = 1'b1;
        Branch_target = 32'h0000_0040;
        tick();
        Branch_taken  = 1'b0;
        check("br_c11_valid", 32'(Valid_out), 32'd0);
        tick();
        check("br_pc_write", 32'(Pc_write), 32'd1);
        check("br_pc_next", Pc_next, 32'h0000_0040);
        check("br_valid", 32'(Valid_out), 32'd0);
        latency = 0;
        tick();
        tick();
        check("br_mem_addr", Mem_addr, 32'h0000_0040);
        check("br_mem_req", 32'(Mem_req), 32'd1);
        push(32'h40);
        run_until_valid("br_target_valid", 15);

        // Branch in COMMIT to the top of memory, then wrap-around
        Branch_taken  = 1'b1;
        Branch_target = 32'hFFFF_FFFC;
        tick();
        Branch_taken  = 1'b0;
        check("commit_br_pc_next", Pc_next, 32'hFFFF_FFFC);
        check("commit_br_pc_write", 32'(Pc_write), 32'd1);
        check("commit_br_valid", 32'(Valid_out), 32'd0);
        push(32'hFFFF_FFFC);
        run_until_valid("wrap_valid", 19);

        // Reset in the middle of a slow memory read
        latency = 5;
        tick();
        tick();
        tick();
        check("midwait_req", 32'(Mem_req), 32'd1);
        Signal_reset = 1'b1;
        tick();
        check("midrst_mem_req", 32'(Mem_req), 32'd0);
        check("midrst_instr_out", Instr_out, 32'h0000_0000);
        check("midrst_valid", 32'(Valid_out), 32'd0);
        check("midrst_pc_out", Pc_out, 32'd0);
        Signal_reset = 1'b0;
        cyc     = 1;
        req_cnt = 0;
        latency = 0;
        push(32'h0);
        run_until_valid("restart_valid", 3);

        check("sb_drained", 32'(sb.size()), 32'd0);
        check("valid_back_to_back", 32'(b2b), 32'd0);
        check("mem_addr_stable", 32'(addr_jumps), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
